instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one parameter: ADDR_W, default 6, instruction-memory address width (capacity 2^ADDR_W words).
REQ-002 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have the port clear, input, 1 bit, which rewinds the write pointer and clears flags.
REQ-005 The block SHALL have the port in_valid, input, 1 bit, meaning an instruction request is present.
REQ-006 The block SHALL have the port in_ready, output, 1 bit, meaning the block can accept a request this cycle.
REQ-007 The block SHALL have the port in_op, input, 5 bits, abstract op code 0..20; the enumeration is in REQ-013.
REQ-008 The block SHALL have the ports in_rs, in_rt and in_rd, inputs, 5 bits each, register fields.
REQ-009 The block SHALL have the port in_imm, input, 16 bits, immediate or branch offset.
REQ-010 The block SHALL have the ports imem_we (output, 1 bit), imem_addr (output, ADDR_W bits) and imem_wdata (output, 32 bits), the instruction-memory write port.
REQ-011 The block SHALL have the ports full (output, 1 bit; memory full), err (output, 1 bit; sticky illegal-op flag) and count (output, ADDR_W+1 bits; words written).

Function
REQ-012 The FSM SHALL have states IDLE, WRITE and FULL. in_ready SHALL be 1 only in IDLE and only when clear=0 and reset=0.
REQ-013 The op enumeration SHALL be:
- 0-9: add, addu, sub, subu, and, or, xor, nor, slt, sltu
- 10-20: lw, sw, beq, bne, andi, ori, xori, addi, addiu, slti, sltiu
REQ-014 R-type encoding (ops 0-9) SHALL be {6'b000000, rs, rt, rd, 5'b00000, funct}, with funct 0x20, 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x27, 0x2A, 0x2B respectively; in_imm is ignored.
REQ-015 I-type encoding (ops 10-20) SHALL be {opcode, rs, rt, imm}, with opcode 0x23, 0x2B, 0x04, 0x05, 0x0C, 0x0D, 0x0E, 0x08, 0x09, 0x0A, 0x0B respectively; in_rd is ignored.
REQ-016 On an accept (in_valid && in_ready) with a legal op, the encoded word SHALL be registered and the FSM SHALL go to WRITE.
REQ-017 In WRITE, imem_we SHALL be 1 for exactly one cycle, with imem_addr = write pointer and imem_wdata = the registered word; latency from accept to write is 1 cycle, and throughput is 1 request per 2 cycles.
REQ-018 On the edge leaving WRITE, the pointer and count SHALL each increment by 1. If count reaches 2^ADDR_W, full SHALL be set and the FSM SHALL enter FULL; otherwise it SHALL return to IDLE.
REQ-019 In FULL, in_ready SHALL be 0 and no write SHALL occur until clear; the pointer SHALL NOT wrap silently.
REQ-020 An accept with in_op >= 21 SHALL set err (sticky), SHALL produce no write and no count change, and the FSM SHALL stay in IDLE.
REQ-021 clear=1 SHALL, on the next edge, set the pointer to 0, count to 0, full to 0 and err to 0, and the FSM to IDLE, in any state.
- If clear is sampled in WRITE, that cycle's write still completes, but clear wins over the increment (count ends at 0).
REQ-022 clear and in_valid together SHALL result in no accept (clear has priority).
REQ-023 imem_we SHALL be 0 outside WRITE, and imem_wdata/imem_addr SHALL hold their last values when imem_we=0.

Reset
REQ-024 reset=1 SHALL, on the next edge, put the FSM in IDLE and set imem_we=0, imem_addr=0, imem_wdata=0, count=0, full=0 and err=0. in_ready SHALL be 0 while reset=1.
REQ-025 A reset asserted in WRITE SHALL suppress the increment; the write in that cycle SHALL NOT be counted.

Structure
REQ-026 Shared package instr_enc_pkg SHALL hold:
- the op enumeration, NUM_OPS=21;
- the opcode and funct constants, identical to those the decode stage uses.
REQ-027 Combinational sub-module instr_field_pack SHALL map (op, rs, rt, rd, imm) to (word[31:0], legal); instr_encoder SHALL contain only the FSM, the registers and the counters.

Verification
REQ-028 The bench SHALL cover these scenarios:
- add, rs=1, rt=2, rd=3 -> one cycle later imem_we=1, addr 0, wdata 0x00221820, count=1.
- lw rs=1, rt=2, imm=4 then beq rs=1, rt=2, imm=0xFFFF -> 0x8C220004 at addr 0, then 0x1022FFFF at addr 1, 2 cycles apart.
- in_op=25 with in_valid -> err=1, no imem_we; a following ori rs=0, rt=5, imm=0x00FF -> 0x340500FF at addr 0, err still 1.
- ADDR_W=2, 4 legal requests -> full=1, in_ready=0; a 5th in_valid is ignored; clear -> count=0, full=0, next write at addr 0.
- clear during WRITE -> the write occurs, count=0 afterwards; in_valid together with clear -> no accept.
- reset mid-stream after 3 writes -> all outputs 0, the next write goes to addr 0.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared op enumeration and MIPS opcode/funct constants for the instruction encoder
// and the decode stage.
package instr_enc_pkg;

  localparam int unsigned NUM_OPS = 21;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_ADDU  = 5'd1,
    OP_SUB   = 5'd2,
    OP_SUBU  = 5'd3,
    OP_AND   = 5'd4,
    OP_OR    = 5'd5,
    OP_XOR   = 5'd6,
    OP_NOR   = 5'd7,
    OP_SLT   = 5'd8,
    OP_SLTU  = 5'd9,
    OP_LW    = 5'd10,
    OP_SW    = 5'd11,
    OP_BEQ   = 5'd12,
    OP_BNE   = 5'd13,
    OP_ANDI  = 5'd14,
    OP_ORI   = 5'd15,
    OP_XORI  = 5'd16,
    OP_ADDI  = 5'd17,
    OP_ADDIU = 5'd18,
    OP_SLTI  = 5'd19,
    OP_SLTIU = 5'd20
  } op_e;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;

  function automatic logic [5:0] op_funct(input op_e op);
    case (op)
      OP_ADD:  return FUNCT_ADD;
      OP_ADDU: return FUNCT_ADDU;
      OP_SUB:  return FUNCT_SUB;
      OP_SUBU: return FUNCT_SUBU;
      OP_AND:  return FUNCT_AND;
      OP_OR:   return FUNCT_OR;
      OP_XOR:  return FUNCT_XOR;
      OP_NOR:  return FUNCT_NOR;
      OP_SLT:  return FUNCT_SLT;
      OP_SLTU: return FUNCT_SLTU;
      default: return '0;
    endcase
  endfunction

  function automatic logic [5:0] op_opcode(input op_e op);
    case (op)
      OP_LW:    return OPC_LW;
      OP_SW:    return OPC_SW;
      OP_BEQ:   return OPC_BEQ;
      OP_BNE:   return OPC_BNE;
      OP_ANDI:  return OPC_ANDI;
      OP_ORI:   return OPC_ORI;
      OP_XORI:  return OPC_XORI;
      OP_ADDI:  return OPC_ADDI;
      OP_ADDIU: return OPC_ADDIU;
      OP_SLTI:  return OPC_SLTI;
      OP_SLTIU: return OPC_SLTIU;
      default:  return OPC_RTYPE;
    endcase
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packing of an abstract op and its register/immediate fields into a
// 32-bit MIPS instruction word, with a legality flag for out-of-range ops.
module instr_field_pack
  import instr_enc_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  always_comb begin
    word_o  = '0;
    legal_o = 1'b0;
    if (op_i < 5'(NUM_OPS)) begin
      legal_o = 1'b1;
      if (op_i <= OP_SLTU) begin
        word_o = {OPC_RTYPE, rs_i, rt_i, rd_i, 5'b00000, op_funct(op_e'(op_i))};
      end else begin
        word_o = {op_opcode(op_e'(op_i)), rs_i, rt_i, imm_i};
      end
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Accepts abstract instruction requests, encodes them and writes them sequentially
// into instruction memory, stopping when the memory is full.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic [ADDR_W:0] LAST_COUNT = {1'b0, {ADDR_W{1'b1}}};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;

  instr_field_pack u_pack (
    .op_i    (in_op),
    .rs_i    (in_rs),
    .rt_i    (in_rt),
    .rd_i    (in_rd),
    .imm_i   (in_imm),
    .word_o  (enc_word),
    .legal_o (enc_legal)
  );

  assign in_ready = (state_q == S_IDLE) && !clear && !reset;
  assign accept   = in_valid && in_ready;

  // The write port is registered at accept so addr/wdata hold after the write cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (clear) begin
      state_d = S_IDLE;
      ptr_d   = '0;
      count_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (enc_legal) begin
              we_d    = 1'b1;
              addr_d  = ptr_q;
              wdata_d = enc_word;
              state_d = S_WRITE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_WRITE: begin
          ptr_d   = ptr_q + 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == LAST_COUNT) begin
            full_d  = 1'b1;
            state_d = S_FULL;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FULL:  state_d = S_FULL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign full       = full_q;
  assign err        = err_q;
  assign count      = count_q;

endmodule
